// File: rtl/pll_clock_manager_pkg.sv
// Package: pll_clock_manager_pkg
// Purpose: shared definitions for the PLL clock manager.
//   - state_t : lock-qualification FSM states (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3)
//   - calc_inc: build-time helper that turns a clock/tick frequency pair into a
//               phase-accumulator increment, rounded to nearest.
//               Example: calc_inc(36.75e6, 1.8432e6, 24) = 841463.
package pll_clock_manager_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Real-to-integer cast rounds to nearest, giving the closest achievable rate.
  function automatic longint calc_inc(input real f_clk, input real f_tick, input int width);
    return longint'(f_tick * (2.0 ** width) / f_clk);
  endfunction

endpackage

// File: rtl/phase_tick_channel.sv
// Module: phase_tick_channel
// Purpose: one fractional-rate tick generator. While active (run && en) the
//   accumulator adds inc every cycle; the carry out of the ACC_WIDTH-bit sum is
//   registered as the tick strobe. When inactive, acc and tick clear on the next edge.
// Ports:
//   clock_in  in   clock
//   reset     in   async active-high reset
//   run       in   manager is in RUN
//   en        in   channel enable
//   inc       in   ACC_WIDTH  per-cycle increment (not latched)
//   tick      out  one-cycle registered strobe
module phase_tick_channel #(
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] inc,
  output logic                 tick
);

  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH:0]   sum;

  // One extra bit captures the carry; the low bits keep the fractional remainder.
  assign sum = {1'b0, acc_reg} + {1'b0, inc};

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end else if (run && en) begin
      acc_reg <= sum[ACC_WIDTH-1:0];
      tick    <= sum[ACC_WIDTH];
    end else begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_clock_manager.sv
// Module: pll_clock_manager
// Purpose: sits behind the PLL in its output domain. Synchronises the raw LOCK
//   signal, qualifies it for LOCK_STABLE cycles, holds reset_out for RESET_HOLD
//   more cycles, then runs CHANNELS phase-accumulator tick generators. Loss of
//   lock while running is recorded in a sticky flag and a saturating counter.
// Ports:
//   clock_in     in   PLL output clock
//   reset        in   async active-high reset
//   pll_locked   in   raw PLL lock (asynchronous)
//   chan_enable  in   CHANNELS            per-channel enable
//   chan_inc     in   CHANNELS*ACC_WIDTH  per-channel increment, ch k at [k*ACC_WIDTH +: ACC_WIDTH]
//   clear_lost   in   clears lock_lost (a simultaneous new loss wins)
//   reset_out    out  synchronous system reset, low only while running
//   ready        out  high while running
//   tick         out  CHANNELS            registered tick strobes
//   lock_lost    out  sticky loss-of-lock flag
//   loss_count   out  LOSS_CNT_WIDTH      saturating loss-of-lock count
module pll_clock_manager
  import pll_clock_manager_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int ACC_WIDTH      = 24,
  parameter int LOCK_STABLE    = 1024,
  parameter int RESET_HOLD     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int LOSS_CNT_WIDTH = 8
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          pll_locked,
  input  logic [CHANNELS-1:0]           chan_enable,
  input  logic [CHANNELS*ACC_WIDTH-1:0] chan_inc,
  input  logic                          clear_lost,
  output logic                          reset_out,
  output logic                          ready,
  output logic [CHANNELS-1:0]           tick,
  output logic                          lock_lost,
  output logic [LOSS_CNT_WIDTH-1:0]     loss_count
);

  localparam int CNT_MAX = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lk_s;
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   run_active;

  assign lk_s       = sync_reg[SYNC_STAGES-1];
  assign run_active = (state_reg == RUN);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      state_reg <= WAIT_LOCK;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A drop of the synchronised lock always wins over counter completion.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lk_s) state_next = STABLE;
      end
      STABLE: begin
        if (!lk_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lk_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lk_s) state_next = WAIT_LOCK;
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Status outputs follow the registered state, so they lag RUN entry/exit by one edge.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      reset_out  <= 1'b1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      reset_out <= !run_active;
      ready     <= run_active;
      if (run_active && !lk_s) begin
        lock_lost <= 1'b1;
        if (loss_count != '1) loss_count <= loss_count + LOSS_CNT_WIDTH'(1);
      end else if (clear_lost) begin
        lock_lost <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      phase_tick_channel #(
        .ACC_WIDTH(ACC_WIDTH)
      ) u_chan (
        .clock_in(clock_in),
        .reset   (reset),
        .run     (run_active),
        .en      (chan_enable[gi]),
        .inc     (chan_inc[gi*ACC_WIDTH +: ACC_WIDTH]),
        .tick    (tick[gi])
      );
    end
  endgenerate

endmodule
